// File: rtl/board_draw.sv
// board_draw: walks the 16x16 board RAM in raster order and issues one plot request per cell,
// handshaking with the block drawer through waitrequest.
module board_draw #(
  parameter bit         SKIP_EN   = 1'b0,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [2:0] mem_rdata,
  output logic       game_plot,
  output logic [3:0] game_x,
  output logic [3:0] game_y,
  output logic [2:0] game_colour,
  input  logic       waitrequest
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT_HI, WAIT_LO, NEXT, DONE} state_t;
  state_t state, state_d;
  logic       busy_d, done_d, plot_d;
  logic [7:0] addr_d;
  logic [3:0] x_d, y_d;
  logic [2:0] colour_d;
  // mem_addr doubles as the {y,x} cell cursor, so incrementing it gives raster order
  always_comb begin
    state_d  = state;
    busy_d   = busy;
    done_d   = 1'b0;
    plot_d   = 1'b0;
    addr_d   = mem_addr;
    x_d      = game_x;
    y_d      = game_y;
    colour_d = game_colour;
    case (state)
      IDLE: if (start) begin
        busy_d  = 1'b1;
        addr_d  = 8'd0;
        state_d = FETCH;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        colour_d = mem_rdata;
        x_d      = mem_addr[3:0];
        y_d      = mem_addr[7:4];
        state_d  = (SKIP_EN && mem_rdata == BG_COLOUR) ? NEXT : ISSUE;
      end
      ISSUE: if (!waitrequest) begin
        plot_d  = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: state_d = waitrequest ? WAIT_LO : WAIT_HI;
      WAIT_LO: state_d = waitrequest ? WAIT_LO : NEXT;
      NEXT: begin
        addr_d  = (mem_addr == 8'hff) ? mem_addr : mem_addr + 8'd1;
        state_d = (mem_addr == 8'hff) ? DONE : FETCH;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      game_plot   <= 1'b0;
      mem_addr    <= 8'd0;
      game_x      <= 4'd0;
      game_y      <= 4'd0;
      game_colour <= 3'b000;
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      game_plot   <= plot_d;
      mem_addr    <= addr_d;
      game_x      <= x_d;
      game_y      <= y_d;
      game_colour <= colour_d;
    end
  end
endmodule

// File: doc/board_draw.md
BOARD_DRAW -- requirements
Module: board_draw

Interface
REQ-001 SHALL have parameter SKIP_EN, default 0; when 1, cells whose colour equals BG_COLOUR are not issued.
REQ-002 SHALL have parameter BG_COLOUR, default 3'b000, the background colour used by SKIP_EN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a full 16x16 board redraw.
REQ-006 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the redraw completes.
REQ-008 SHALL have port mem_addr, output, 8 bits: board RAM read address, {y[3:0], x[3:0]}.
REQ-009 SHALL have port mem_rdata, input, 3 bits: board RAM colour, valid one cycle after mem_addr is presented (synchronous read).
REQ-010 SHALL have port game_plot, output, 1 bit: cell plot request to game_plot.
REQ-011 SHALL have ports game_x and game_y, outputs, 4 bits each: cell coordinates.
REQ-012 SHALL have port game_colour, output, 3 bits: cell colour.
REQ-013 SHALL have port waitrequest, input, 1 bit: from game_plot; high while the 6x6 block is being drawn.

Function
REQ-014 SHALL implement states IDLE, FETCH, LATCH, ISSUE, WAIT_HI, WAIT_LO, NEXT, DONE; all outputs SHALL be registered.
REQ-015 IDLE: on a posedge with start=1, SHALL set busy=1, x=y=0, mem_addr=0, and go to FETCH; start in any other state SHALL be ignored.
REQ-016 FETCH: SHALL hold mem_addr={y,x} for one cycle, then go to LATCH.
REQ-017 LATCH: SHALL capture mem_rdata into game_colour and x,y into game_x,game_y. If SKIP_EN=1 and mem_rdata==BG_COLOUR, SHALL go to NEXT; otherwise to ISSUE.
REQ-018 ISSUE: SHALL drive game_plot=1 for exactly one cycle; entry requires waitrequest=0, otherwise SHALL stay in ISSUE with game_plot=0 until waitrequest=0.
REQ-019 WAIT_HI: game_plot=0; SHALL wait until waitrequest=1, then go to WAIT_LO.
REQ-020 WAIT_LO: SHALL wait until waitrequest=0, then go to NEXT.
REQ-021 game_x, game_y and game_colour SHALL remain stable from ISSUE through the end of WAIT_LO.
REQ-022 NEXT: SHALL advance in raster order, x fastest. x=15 SHALL wrap x to 0 and increment y. At x=15,y=15 SHALL go to DONE; otherwise SHALL update mem_addr and go to FETCH.
REQ-023 DONE: SHALL pulse done=1 for one cycle, clear busy on the same edge, and return to IDLE.
REQ-024 First game_plot assertion SHALL occur 3 cycles after the start-accepting edge (FETCH, LATCH, ISSUE), given waitrequest=0.
REQ-025 A start pulse arriving on the same edge as done SHALL be ignored; a new start SHALL be accepted from IDLE only.

Reset
REQ-026 On posedge with rst_n=0, SHALL enter IDLE with game_plot=0, busy=0, done=0, mem_addr=0, game_x=0, game_y=0, game_colour=3'b000.
REQ-027 Reset mid-redraw SHALL abort with no further game_plot pulses; an in-progress responder draw is not cancelled.

Verification
REQ-028 Reset then start, RAM all 3'b001, responder model with waitrequest high for 36 cycles -> 256 game_plot pulses in raster order (0,0),(1,0)…(15,15), each colour 001, then one done pulse with busy falling.
REQ-029 RAM[{4'd8,4'd5}]=3'b111, others 000, SKIP_EN=1 -> exactly one game_plot with game_x=5, game_y=8, game_colour=111, then done.
REQ-030 waitrequest held high at start -> design stays in ISSUE with game_plot=0 until release, then pulses once; x, y and colour stable across WAIT_HI/WAIT_LO.
REQ-031 Assert rst_n=0 during cell (3,2) WAIT_LO -> next edge game_plot=0, busy=0, mem_addr=0; no pulses until a new start.
REQ-032 start pulsed repeatedly while busy -> ignored; exactly 256 plots and one done pulse.
REQ-033 Start edge at t -> game_plot=1 at t+3 cycles, game_x=0, game_y=0.
